// File: rtl/array_update_pkg.sv
// ============================================================================
// Module      : array_update_pkg
// Description : Shared types and default sizes for array_update_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package array_update_pkg;

  localparam int DEF_NUM_REQ   = 2;
  localparam int DEF_NUM_ELEMS = 4;
  localparam int DEF_ELEM_W    = 33;
  localparam int DEF_IDX_W     = 32;
  localparam int REQ_ID_W      = $clog2(DEF_NUM_REQ);
  // Wide enough for the largest supported requester count (8).
  localparam int ID_MAX_W      = 3;

  typedef logic [DEF_ELEM_W-1:0] elem_t;
  typedef logic [DEF_IDX_W-1:0]  idx_t;

  typedef struct packed {
    idx_t                idx;
    elem_t               data;
    logic [ID_MAX_W-1:0] id;
  } upd_req_t;

endpackage

`default_nettype wire

// File: rtl/array_update_sched_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; owns the rotating priority pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_hit;

  function automatic int wrap(input int a);
    return (a >= NUM_REQ) ? a - NUM_REQ : a;
  endfunction

  // Scan from the pointer, wrapping; the first requester seen wins.
  always_comb begin
    grant     = '0;
    w_hit     = 1'b0;
    w_ptr_nxt = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_hit && req[wrap(int'(r_ptr) + k)]) begin
        grant[wrap(int'(r_ptr) + k)] = 1'b1;
        w_hit                        = 1'b1;
        w_ptr_nxt                    = PTR_W'(wrap(int'(r_ptr) + k + 1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/array_update_sched.sv
// ============================================================================
// Module      : array_update_sched
// Description : Round-robin shared 2-stage array-update datapath.
//               Optional macro ARRAY_UPD_BOUNDS_CHECK_EN adds done_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_update_sched
  import array_update_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int NUM_ELEMS = DEF_NUM_ELEMS,
  parameter int ELEM_W    = DEF_ELEM_W,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*IDX_W-1:0]    req_index,
  input  logic [NUM_REQ*ELEM_W-1:0]   req_data,
  output logic [NUM_ELEMS*ELEM_W-1:0] arr_out,
  output logic                        done_valid,
`ifdef ARRAY_UPD_BOUNDS_CHECK_EN
  output logic                        done_err,
`endif
  output logic [$clog2(NUM_REQ)-1:0]  done_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  upd_req_t          w_sel;
  logic              w_xfer;
  logic              r_p0_valid;
  upd_req_t          r_p0;
  logic [ELEM_W-1:0] r_arr [NUM_ELEMS];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .grant (req_ready)
  );

  // No backpressure: any valid request produces a transfer this cycle.
  assign w_xfer = |req_valid;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        w_sel.idx  = req_index[i*IDX_W +: IDX_W];
        w_sel.data = req_data[i*ELEM_W +: ELEM_W];
        w_sel.id   = ID_MAX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p0_valid <= 1'b0;
      r_p0       <= '0;
    end else begin
      r_p0_valid <= w_xfer;
      if (w_xfer) begin
        r_p0 <= w_sel;
      end
    end
  end

  // Full-width index compare: out-of-range writes match no element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_ELEMS; k++) begin
        r_arr[k] <= '0;
      end
      done_valid <= 1'b0;
      done_id    <= '0;
    end else begin
      done_valid <= r_p0_valid;
      if (r_p0_valid) begin
        done_id <= r_p0.id[ID_W-1:0];
      end
      for (int k = 0; k < NUM_ELEMS; k++) begin
        if (clear) begin
          r_arr[k] <= '0;
        end else if (r_p0_valid && (r_p0.idx == IDX_W'(k))) begin
          r_arr[k] <= r_p0.data;
        end
      end
    end
  end

`ifdef ARRAY_UPD_BOUNDS_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_err <= 1'b0;
    end else begin
      done_err <= r_p0_valid && (r_p0.idx >= IDX_W'(NUM_ELEMS));
    end
  end

`ifndef SYNTHESIS
  a_err_implies_valid: assert property (
    @(posedge clk) disable iff (rst) done_err |-> done_valid
  );
`endif
`endif

  for (genvar k = 0; k < NUM_ELEMS; k++) begin : g_arr
    assign arr_out[k*ELEM_W +: ELEM_W] = r_arr[k];
  end

endmodule

`default_nettype wire

// File: tb/tb_array_update_sched.sv
// ============================================================================
// Module      : tb_array_update_sched
// Description : Directed self-checking bench for array_update_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_array_update_sched;

  localparam int NR = 2;
  localparam int NE = 4;
  localparam int EW = 33;
  localparam int IW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*IW-1:0] req_index;
  logic [NR*EW-1:0] req_data;
  logic [NE*EW-1:0] arr_out;
  logic             done_valid;
  logic [0:0]       done_id;
`ifdef ARRAY_UPD_BOUNDS_CHECK_EN
  logic             done_err;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_ptr;
  logic [EW-1:0] exp_arr [NE];

  always #5 clk = ~clk;

  array_update_sched #(
    .NUM_REQ(NR), .NUM_ELEMS(NE), .ELEM_W(EW), .IDX_W(IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_index  (req_index),
    .req_data   (req_data),
    .arr_out    (arr_out),
    .done_valid (done_valid),
`ifdef ARRAY_UPD_BOUNDS_CHECK_EN
    .done_err   (done_err),
`endif
    .done_id    (done_id)
  );

  function automatic logic [NE*EW-1:0] model_flat();
    logic [NE*EW-1:0] f;
    for (int k = 0; k < NE; k++) f[k*EW +: EW] = exp_arr[k];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [IW-1:0] idx,
                         input logic [EW-1:0] d);
    req_valid[i]           = v;
    req_index[i*IW +: IW]  = idx;
    req_data[i*EW +: EW]   = d;
  endtask

  task automatic test_reset();
    n_cmp++; if (arr_out !== '0) begin n_bad++; $display("FAIL reset_arr: got %h expected 0", arr_out); end
    n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL reset_done_valid: got %b expected 0", done_valid); end
    n_cmp++; if (done_id !== 1'b0) begin n_bad++; $display("FAIL reset_done_id: got %b expected 0", done_id); end
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
  endtask

  task automatic test_basic();
    set_req(0, 1'b1, 32'd1, 33'h2A);
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL basic_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_done: got %b expected 0", done_valid); end
    n_cmp++; if (arr_out !== '0) begin n_bad++; $display("FAIL basic_early_arr: got %h expected 0", arr_out); end
    tick();
    exp_arr[1] = 33'h2A;
    n_cmp++; if (arr_out !== model_flat()) begin n_bad++; $display("FAIL basic_arr: got %h expected %h", arr_out, model_flat()); end
    n_cmp++; if (done_valid !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b expected 1", done_valid); end
    n_cmp++; if (done_id !== 1'b0) begin n_bad++; $display("FAIL basic_done_id: got %b expected 0", done_id); end
`ifdef ARRAY_UPD_BOUNDS_CHECK_EN
    n_cmp++; if (done_err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b expected 0", done_err); end
`endif
    tick();
    n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width: got %b expected 0", done_valid); end
    exp_ptr = 1;
  endtask

  task automatic test_fairness();
    int g [10];
    int cnt0 = 0;
    int cnt1 = 0;
    set_req(0, 1'b1, 32'd0, 33'd0);
    set_req(1, 1'b1, 32'd0, 33'd1);
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req_valid = '0;
      if (c < 8) begin
        #1;
        n_cmp++; if (req_ready !== (2'b01 << exp_ptr)) begin n_bad++; $display("FAIL fair_ready[%0d]: got %b expected %b", c, req_ready, 2'b01 << exp_ptr); end
        cnt0 += int'(req_ready[0]);
        cnt1 += int'(req_ready[1]);
        g[c] = exp_ptr;
        exp_ptr = 1 - exp_ptr;
      end
      if (c >= 2) begin
        exp_arr[0] = EW'(g[c-2]);
        n_cmp++; if (arr_out !== model_flat()) begin n_bad++; $display("FAIL fair_arr[%0d]: got %h expected %h", c, arr_out, model_flat()); end
        n_cmp++; if (done_valid !== 1'b1 || done_id !== 1'(g[c-2])) begin n_bad++; $display("FAIL fair_done[%0d]: got v=%b id=%b expected v=1 id=%0d", c, done_valid, done_id, g[c-2]); end
      end
      tick();
    end
    n_cmp++; if (cnt0 !== 4 || cnt1 !== 4) begin n_bad++; $display("FAIL fair_counts: got %0d/%0d expected 4/4", cnt0, cnt1); end
  endtask

  task automatic test_same_index();
    req_valid = '0;
    set_req(0, 1'b1, 32'd3, 33'd5);
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL hazard_ready0: got %b expected 01", req_ready); end
    tick();
    req_valid = '0;
    set_req(1, 1'b1, 32'd3, 33'd9);
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL hazard_ready1: got %b expected 10", req_ready); end
    tick();
    req_valid = '0;
    exp_arr[3] = 33'd5;
    n_cmp++; if (arr_out !== model_flat()) begin n_bad++; $display("FAIL hazard_first: got %h expected %h", arr_out, model_flat()); end
    tick();
    exp_arr[3] = 33'd9;
    n_cmp++; if (arr_out !== model_flat()) begin n_bad++; $display("FAIL hazard_second: got %h expected %h", arr_out, model_flat()); end
    n_cmp++; if (done_id !== 1'b1) begin n_bad++; $display("FAIL hazard_done_id: got %b expected 1", done_id); end
    exp_ptr = 0;
  endtask

  task automatic test_out_of_bounds();
    logic [IW-1:0] tbl [4];
    tbl[0] = 32'd7; tbl[1] = 32'd4; tbl[2] = 32'h8000_0001; tbl[3] = 32'hFFFF_FFFF;
    for (int t = 0; t < 4; t++) begin
      set_req(0, 1'b1, tbl[t], 33'd1);
      tick();
      req_valid = '0;
      tick();
      n_cmp++; if (done_valid !== 1'b1) begin n_bad++; $display("FAIL oob_done[%0d]: got %b expected 1", t, done_valid); end
      n_cmp++; if (arr_out !== model_flat()) begin n_bad++; $display("FAIL oob_arr[%0d]: got %h expected %h", t, arr_out, model_flat()); end
`ifdef ARRAY_UPD_BOUNDS_CHECK_EN
      n_cmp++; if (done_err !== 1'b1) begin n_bad++; $display("FAIL oob_err[%0d]: got %b expected 1", t, done_err); end
`endif
    end
  endtask

  task automatic test_clear();
    set_req(0, 1'b1, 32'd2, 33'd7);
    tick();
    set_req(0, 1'b1, 32'd0, 33'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    req_valid = '0;
    for (int k = 0; k < NE; k++) exp_arr[k] = '0;
    n_cmp++; if (arr_out !== '0) begin n_bad++; $display("FAIL clear_arr: got %h expected 0", arr_out); end
    n_cmp++; if (done_valid !== 1'b1) begin n_bad++; $display("FAIL clear_done: got %b expected 1", done_valid); end
    tick();
    exp_arr[0] = 33'd3;
    n_cmp++; if (arr_out !== model_flat()) begin n_bad++; $display("FAIL clear_next_arr: got %h expected %h", arr_out, model_flat()); end
    n_cmp++; if (done_valid !== 1'b1 || done_id !== 1'b0) begin n_bad++; $display("FAIL clear_next_done: got v=%b id=%b expected v=1 id=0", done_valid, done_id); end
    tick();
    n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL clear_idle: got %b expected 0", done_valid); end
  endtask

  task automatic test_reset_midflight();
    set_req(0, 1'b1, 32'd1, 33'h55);
    tick();
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < NE; k++) exp_arr[k] = '0;
    n_cmp++; if (arr_out !== '0) begin n_bad++; $display("FAIL midrst_arr: got %h expected 0", arr_out); end
    n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b expected 0", done_valid); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (done_valid !== 1'b0 || arr_out !== '0) begin n_bad++; $display("FAIL midrst_lost[%0d]: got v=%b arr=%h expected v=0 arr=0", c, done_valid, arr_out); end
    end
    set_req(0, 1'b1, 32'd3, 33'd0);
    set_req(1, 1'b1, 32'd3, 33'd0);
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL midrst_ptr: got %b expected 01", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    req_valid = '0;
    req_index = '0;
    req_data  = '0;
    exp_ptr   = 0;
    for (int k = 0; k < NE; k++) exp_arr[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    tick();
    test_basic();
    test_fairness();
    test_same_index();
    test_out_of_bounds();
    test_clear();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
